core_exu_adder_pipe: RTL and testbench
======================================

# core_exu_adder_pipe

Parametrised, pipelined add/subtract/compare unit for the execute stage. It replaces the single-cycle RV32 adder and is generalised in data width and pipeline depth. The carry chain is split into `NUM_STAGES` equal slices, with one slice per register stage. The unit adds a valid/ready handshake, back-pressure, flush and a tag that passes through unchanged, and it produces the result plus signed/unsigned/equality flags for ALU, SLT and branch resolution.

## Interface
Parameters:
- `XLEN`, 32, operand/result width; must be divisible by `NUM_STAGES`
- `NUM_STAGES`, 2, pipeline depth and carry-chain slice count (≥1); slice width `CW = XLEN/NUM_STAGES`
- `TAG_W`, 5, width of opaque tag (e.g. rd index)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `flush`  in  1  synchronous kill of all in-flight ops
- `in_valid`  in  1  request valid
- `in_ready`  out  1  unit can accept request this cycle
- `in_op`  in  4  operation code (`EXU_OP_*`)
- `in_a`  in  XLEN  operand A (rs1 or pc, muxed upstream)
- `in_b`  in  XLEN  operand B (rs2 or imm, muxed upstream)
- `in_tag`  in  TAG_W  carried to output unchanged
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts result
- `out_res`  out  XLEN  result
- `out_tag`  out  TAG_W  tag of result
- `out_lt`, `out_ltu`, `out_eq`  out  1 each  signed-less, unsigned-less, equal (A vs B; meaningful for subtracting ops)

## Operation
- Op codes:
  - 0 ADD, 1 SUB, 2 SLT, 3 SLTU, 4 BEQ, 5 BNE, 6 BLT, 7 BGE, 8 BLTU, 9 BGEU.
  - Codes 10–15 behave as ADD.
  - Every op except ADD subtracts: B is inverted and carry-in is 1.
- Stage k (0-based) adds bits `[k*CW +: CW]` using the carry from stage k-1. It also registers:
  - the upper operand slices still to be added,
  - the lower sum slices already computed,
  - a running zero flag,
  - op, tag, and the sign bits of A and B.
- Flags, computed at the final stage:
  - `ltu = ~carry_out`
  - `lt = (a_msb != b_msb) ? a_msb : sum_msb`
  - `eq = (sum == 0)`
- Result select:
  - ADD/SUB: sum.
  - SLT: zero-extended lt. SLTU: ltu.
  - BEQ: eq. BNE: ~eq. BLT: lt. BGE: ~lt. BLTU: ltu. BGEU: ~ltu.
  - All compare results are zero-extended to XLEN.
- Arithmetic wraps modulo 2^XLEN. There is no overflow output.
- Handshake:
  - Each stage has its own valid bit and advances when it is empty or the next stage advances (bubble-collapsing).
  - The final stage advances when `out_ready | ~out_valid`.
  - `in_ready = ~flush & (~v[0] | adv[0])`.
- Held outputs: while `out_valid & ~out_ready`, `out_res`, `out_tag` and the flags hold stable.
- Flush:
  - All valid bits clear at the next edge.
  - Payload registers need not clear.
  - A request presented in the flush cycle is not accepted.
  - `out_valid` falls the cycle after `flush`.
- Reset: all valid bits 0; `out_res`, `out_tag` and the flags 0; `in_ready` = 1 once `rst_n` is high.

## Timing
- Latency: `NUM_STAGES` cycles from an accepted `in_valid` to `out_valid`, when there is no back-pressure.
- Throughput: 1 op/cycle.
- Outputs are driven directly from registers. `in_ready` is combinational from `out_ready`, `flush` and the stage valids.
- `NUM_STAGES=1` is a single registered adder (1-cycle latency).
- Critical path is one CW-bit carry chain, plus zero detect and the result mux in the last stage.
- Simultaneous accept and emit in the same cycle is legal and must not lose or duplicate an op.
- Reset asserted mid-operation drops all in-flight ops immediately (asynchronous).

## Structure
- Shared package `core_exu_pkg`:
  - `EXU_OP_*` codes and `EXU_OP_W=4`.
  - helper `exu_op_is_sub(op)`.
- Sub-module `core_exu_add_slice`:
  - one CW-bit slice adder with carry in/out and slice-zero output, combinational;
  - instantiated `NUM_STAGES` times with a generate loop;
  - the top level holds the stage registers and handshake.

## Test plan
- ADD 0xFFFF_FFFF + 0x0000_0001, tag 3, `NUM_STAGES=2` → after 2 cycles: `out_res`=0, `out_eq`=1, `out_tag`=3; the carry crosses the slice boundary at bit 16.
- SLT A=0x8000_0000, B=0x0000_0001 → `out_res`=1, `out_lt`=1, `out_ltu`=0.
- SLTU on the same operands → `out_res`=0.
- BGEU A=5, B=5 → `out_res`=1, `out_eq`=1.
- BNE on the same operands → `out_res`=0.
- Back-pressure, `NUM_STAGES=4`: stream 8 ADDs (i+i, tags 0–7) with `out_ready` low for cycles 3–6:
  - `in_ready` drops once all 4 stages are full;
  - results emerge in order with correct sums and no loss or duplication.
- Flush with 2 ops in flight and `in_valid`=1 in the flush cycle → `out_valid`=0 the next cycle, and no result for any of the 3 ops ever appears.
- Assert `rst_n`=0 mid-stream, asynchronously between edges → `out_valid` and all flags drop to 0 immediately; `in_ready`=1 after release.

Source files
------------

// File: rtl/core_exu_adder_pipe_pkg.sv
// Shared definitions for the execute-stage adder: op codes, op width and the
// subtract-select helper.
package core_exu_pkg;

    localparam int EXU_OP_W = 4;

    typedef enum logic [EXU_OP_W-1:0] {
        EXU_OP_ADD  = 4'd0,
        EXU_OP_SUB  = 4'd1,
        EXU_OP_SLT  = 4'd2,
        EXU_OP_SLTU = 4'd3,
        EXU_OP_BEQ  = 4'd4,
        EXU_OP_BNE  = 4'd5,
        EXU_OP_BLT  = 4'd6,
        EXU_OP_BGE  = 4'd7,
        EXU_OP_BLTU = 4'd8,
        EXU_OP_BGEU = 4'd9
    } exu_op_e;

    // Codes 10..15 alias ADD, so only the defined non-ADD codes subtract.
    function automatic logic exu_op_is_sub(input logic [EXU_OP_W-1:0] op);
        return (op >= EXU_OP_SUB) && (op <= EXU_OP_BGEU);
    endfunction

endpackage

// File: rtl/core_exu_adder_pipe_if.sv
// Request/response handshake bundle of the pipelined adder.
interface core_exu_adder_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_op;
    logic [XLEN-1:0]  in_a;
    logic [XLEN-1:0]  in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_res;
    logic [TAG_W-1:0] out_tag;
    logic             out_lt;
    logic             out_ltu;
    logic             out_eq;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_res, out_tag, out_lt, out_ltu, out_eq
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_res, out_tag, out_lt, out_ltu, out_eq
    );
endinterface

// File: rtl/core_exu_add_slice.sv
// One CW-bit carry-chain slice of the pipelined adder, purely combinational.
module core_exu_add_slice #(
    parameter int CW = 16
) (
    input  logic [CW-1:0] a_i,
    input  logic [CW-1:0] b_i,
    input  logic          c_i,
    output logic [CW-1:0] s_o,
    output logic          c_o,
    output logic          zero_o
);
    assign {c_o, s_o} = {1'b0, a_i} + {1'b0, b_i} + {{CW{1'b0}}, c_i};
    assign zero_o     = (s_o == {CW{1'b0}});
endmodule

// File: rtl/core_exu_adder_pipe.sv
// Pipelined add/sub/compare unit: one carry slice per stage, bubble-collapsing
// valid/ready pipeline, flush, and registered result/flags at the last stage.
module core_exu_adder_pipe
    import core_exu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NUM_STAGES = 2,
    parameter int TAG_W      = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    core_exu_adder_pipe_if.slave bus
);
    localparam int CW = XLEN / NUM_STAGES;
    localparam int L  = NUM_STAGES - 1;
    localparam logic [XLEN-1:0] SL_MASK = {XLEN{1'b1}} >> (XLEN - CW);

    // Per stage, m_q holds finished sum slices below and untouched A slices above.
    logic [NUM_STAGES-1:0] v_q;
    logic [XLEN-1:0]       m_q   [NUM_STAGES];
    logic [XLEN-1:0]       b_q   [NUM_STAGES];
    logic                  c_q   [NUM_STAGES];
    logic                  z_q   [NUM_STAGES];
    logic [EXU_OP_W-1:0]   op_q  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_q [NUM_STAGES];
    logic [XLEN-1:0]       res_q;
    logic                  lt_q, ltu_q, eq_q;

    logic [NUM_STAGES-1:0] adv, src_v, c_src, z_src, co, zs;
    logic [XLEN-1:0]       m_src   [NUM_STAGES];
    logic [XLEN-1:0]       b_src   [NUM_STAGES];
    logic [XLEN-1:0]       m_d     [NUM_STAGES];
    logic [EXU_OP_W-1:0]   op_src  [NUM_STAGES];
    logic [TAG_W-1:0]      tag_src [NUM_STAGES];
    logic [CW-1:0]         sum_sl  [NUM_STAGES];
    logic                  in_ready_s;
    logic [XLEN-1:0]       res_d;
    logic                  lt_d, ltu_d, eq_d, a_msb, b_msb, bit_d, is_cmp;

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign m_src[k]   = bus.in_a;
            assign b_src[k]   = bus.in_b ^ {XLEN{exu_op_is_sub(bus.in_op)}};
            assign c_src[k]   = exu_op_is_sub(bus.in_op);
            assign z_src[k]   = 1'b1;
            assign op_src[k]  = bus.in_op;
            assign tag_src[k] = bus.in_tag;
            assign src_v[k]   = bus.in_valid & in_ready_s;
        end else begin : g_body
            assign m_src[k]   = m_q[k-1];
            assign b_src[k]   = b_q[k-1];
            assign c_src[k]   = c_q[k-1];
            assign z_src[k]   = z_q[k-1];
            assign op_src[k]  = op_q[k-1];
            assign tag_src[k] = tag_q[k-1];
            assign src_v[k]   = v_q[k-1];
        end

        core_exu_add_slice #(.CW(CW)) u_slice (
            .a_i    (m_src[k][k*CW +: CW]),
            .b_i    (b_src[k][k*CW +: CW]),
            .c_i    (c_src[k]),
            .s_o    (sum_sl[k]),
            .c_o    (co[k]),
            .zero_o (zs[k])
        );

        assign m_d[k] = (m_src[k] & ~(SL_MASK << (k*CW))) | (XLEN'(sum_sl[k]) << (k*CW));
    end

    // Advance chain: a stage moves when empty or when its successor moves.
    always_comb begin
        adv    = '0;
        adv[L] = bus.out_ready | ~v_q[L];
        for (int k = L - 1; k >= 0; k--) begin
            adv[k] = ~v_q[k] | adv[k+1];
        end
    end

    assign in_ready_s = ~flush & adv[0];

    // Final-stage flags and result select; b_src is pre-inverted for subtracts.
    always_comb begin
        a_msb  = m_src[L][XLEN-1];
        b_msb  = b_src[L][XLEN-1] ^ exu_op_is_sub(op_src[L]);
        ltu_d  = ~co[L];
        lt_d   = (a_msb != b_msb) ? a_msb : m_d[L][XLEN-1];
        eq_d   = z_src[L] & zs[L];
        bit_d  = 1'b0;
        is_cmp = 1'b1;
        case (op_src[L])
            EXU_OP_SLT,  EXU_OP_BLT:  bit_d = lt_d;
            EXU_OP_SLTU, EXU_OP_BLTU: bit_d = ltu_d;
            EXU_OP_BEQ:               bit_d = eq_d;
            EXU_OP_BNE:               bit_d = ~eq_d;
            EXU_OP_BGE:               bit_d = ~lt_d;
            EXU_OP_BGEU:              bit_d = ~ltu_d;
            default:                  is_cmp = 1'b0;
        endcase
        if (is_cmp) begin
            res_d = {{(XLEN-1){1'b0}}, bit_d};
        end else begin
            res_d = m_d[L];
        end
    end

    // Stage valids, stage payloads and the held output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q   <= '0;
            res_q <= '0;
            lt_q  <= 1'b0;
            ltu_q <= 1'b0;
            eq_q  <= 1'b0;
            for (int k = 0; k < NUM_STAGES; k++) begin
                m_q[k]   <= '0;
                b_q[k]   <= '0;
                c_q[k]   <= 1'b0;
                z_q[k]   <= 1'b0;
                op_q[k]  <= '0;
                tag_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (flush) begin
                    v_q[k] <= 1'b0;
                end else if (adv[k]) begin
                    v_q[k] <= src_v[k];
                end
                if (adv[k] & src_v[k]) begin
                    m_q[k]   <= m_d[k];
                    b_q[k]   <= b_src[k];
                    c_q[k]   <= co[k];
                    z_q[k]   <= z_src[k] & zs[k];
                    op_q[k]  <= op_src[k];
                    tag_q[k] <= tag_src[k];
                end
            end
            if (adv[L] & src_v[L]) begin
                res_q <= res_d;
                lt_q  <= lt_d;
                ltu_q <= ltu_d;
                eq_q  <= eq_d;
            end
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = v_q[L];
    assign bus.out_res   = res_q;
    assign bus.out_tag   = tag_q[L];
    assign bus.out_lt    = lt_q;
    assign bus.out_ltu   = ltu_q;
    assign bus.out_eq    = eq_q;
endmodule

// File: tb/tb_core_exu_adder_pipe.sv
// Scoreboard bench for core_exu_adder_pipe: a 2-stage and a 4-stage instance.
module tb_core_exu_adder_pipe;
    import core_exu_pkg::*;

    typedef struct packed {
        logic [31:0] res;
        logic [4:0]  tag;
        logic        lt;
        logic        ltu;
        logic        eq;
        logic        cmp;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush2, flush4;
    int   nerr = 0;
    int   nchk = 0;
    int   out4_cnt;
    int   sent4;
    bit   stall_seen;
    exp_t q2[$];
    exp_t q4[$];

    always #5 clk = ~clk;

    core_exu_adder_pipe_if #(.XLEN(32), .TAG_W(5)) if2 ();
    core_exu_adder_pipe_if #(.XLEN(32), .TAG_W(5)) if4 ();

    core_exu_adder_pipe #(.XLEN(32), .NUM_STAGES(2), .TAG_W(5)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .flush(flush2), .bus(if2)
    );
    core_exu_adder_pipe #(.XLEN(32), .NUM_STAGES(4), .TAG_W(5)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .flush(flush4), .bus(if4)
    );

    function automatic exp_t model(input logic [3:0] op, input logic [31:0] a,
                                   input logic [31:0] b, input logic [4:0] tag);
        exp_t        e;
        logic [31:0] s;
        logic        sub;
        sub   = (op >= 4'd1) && (op <= 4'd9);
        s     = sub ? (a - b) : (a + b);
        e.lt  = ($signed(a) < $signed(b));
        e.ltu = (a < b);
        e.eq  = (s == 32'd0);
        e.cmp = sub;
        e.tag = tag;
        case (op)
            4'd2, 4'd6: e.res = {31'd0, e.lt};
            4'd3, 4'd8: e.res = {31'd0, e.ltu};
            4'd4:       e.res = {31'd0, e.eq};
            4'd5:       e.res = {31'd0, !e.eq};
            4'd7:       e.res = {31'd0, !e.lt};
            4'd9:       e.res = {31'd0, !e.ltu};
            default:    e.res = s;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", name, obs, exp);
        end
    endtask

    task automatic cmp_out(input string p, input logic [31:0] res, input logic [4:0] tag,
                           input logic lt, input logic ltu, input logic eq, input exp_t e);
        chk({p, "_res"}, res, e.res);
        chk({p, "_tag"}, 32'(tag), 32'(e.tag));
        chk({p, "_eq"}, 32'(eq), 32'(e.eq));
        if (e.cmp) begin
            chk({p, "_lt"}, 32'(lt), 32'(e.lt));
            chk({p, "_ltu"}, 32'(ltu), 32'(e.ltu));
        end
    endtask

    task automatic drive2(input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
        if2.in_valid = v;
        if2.in_op    = op;
        if2.in_a     = a;
        if2.in_b     = b;
        if2.in_tag   = tag;
    endtask

    // One clock: observe at negedge, then return 1 time unit after posedge.
    task automatic step();
        @(negedge clk);
        if (if2.out_valid === 1'b1) begin
            chk("d2_out_expected", (q2.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (q2.size() != 0) begin
                cmp_out("d2", if2.out_res, if2.out_tag, if2.out_lt, if2.out_ltu, if2.out_eq, q2[0]);
                if (if2.out_ready === 1'b1) void'(q2.pop_front());
            end
        end
        if (flush2) q2.delete();
        if (if2.in_valid && if2.in_ready) q2.push_back(model(if2.in_op, if2.in_a, if2.in_b, if2.in_tag));
        if (if4.out_valid === 1'b1) begin
            chk("d4_out_expected", (q4.size() != 0) ? 32'd1 : 32'd0, 32'd1);
            if (q4.size() != 0) begin
                cmp_out("d4", if4.out_res, if4.out_tag, if4.out_lt, if4.out_ltu, if4.out_eq, q4[0]);
                if (if4.out_ready === 1'b1) begin
                    void'(q4.pop_front());
                    out4_cnt++;
                end
            end
        end
        if (if4.in_valid && !if4.in_ready) stall_seen = 1'b1;
        if (if4.in_valid && if4.in_ready) begin
            q4.push_back(model(if4.in_op, if4.in_a, if4.in_b, if4.in_tag));
            sent4++;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush2 = 1'b0; flush4 = 1'b0;
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        if2.out_ready = 1'b1;
        if4.in_valid = 1'b0; if4.in_op = 4'd0; if4.in_a = 32'd0; if4.in_b = 32'd0;
        if4.in_tag = 5'd0; if4.out_ready = 1'b1;
        out4_cnt = 0; sent4 = 0; stall_seen = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        chk("rst_in_ready2", 32'(if2.in_ready), 32'd1);
        chk("rst_out_valid2", 32'(if2.out_valid), 32'd0);
        chk("rst_out_res2", if2.out_res, 32'd0);
        chk("rst_out_tag2", 32'(if2.out_tag), 32'd0);
        chk("rst_flags2", 32'({if2.out_lt, if2.out_ltu, if2.out_eq}), 32'd0);
        chk("rst_in_ready4", 32'(if4.in_ready), 32'd1);
        chk("rst_out_valid4", 32'(if4.out_valid), 32'd0);
        @(posedge clk); #1;

        // ADD with carry across the slice boundary; explicit 2-cycle latency
        drive2(1'b1, 4'd0, 32'hFFFF_FFFF, 32'h0000_0001, 5'd3);
        step();
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        chk("lat_not_yet", 32'(if2.out_valid), 32'd0);
        step();
        chk("lat_valid", 32'(if2.out_valid), 32'd1);
        chk("add_res", if2.out_res, 32'd0);
        chk("add_eq", 32'(if2.out_eq), 32'd1);
        chk("add_tag", 32'(if2.out_tag), 32'd3);

        // Back-to-back directed ops
        drive2(1'b1, 4'd2, 32'h8000_0000, 32'h0000_0001, 5'd4);  step();
        drive2(1'b1, 4'd3, 32'h8000_0000, 32'h0000_0001, 5'd5);  step();
        drive2(1'b1, 4'd9, 32'd5, 32'd5, 5'd6);                  step();
        drive2(1'b1, 4'd5, 32'd5, 32'd5, 5'd7);                  step();
        drive2(1'b1, 4'd1, 32'd3, 32'd5, 5'd8);                  step();
        drive2(1'b1, 4'd6, 32'hFFFF_FFFF, 32'd0, 5'd9);          step();
        drive2(1'b1, 4'd7, 32'h7FFF_FFFF, 32'h8000_0000, 5'd10); step();
        drive2(1'b1, 4'd8, 32'h0001_0000, 32'h0000_FFFF, 5'd11); step();
        drive2(1'b1, 4'd4, 32'h1234_0000, 32'h1234_0001, 5'd12); step();
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        repeat (4) step();
        chk("dir_drained", 32'(q2.size()), 32'd0);

        // Random ops with random back-pressure
        for (int i = 0; i < 60; i++) begin
            drive2(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), $urandom(),
                   (i % 4 == 0) ? if2.in_a : $urandom(), 5'($urandom_range(0, 31)));
            if2.out_ready = 1'($urandom_range(0, 2) != 0);
            step();
        end
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        if2.out_ready = 1'b1;
        repeat (6) step();
        chk("rnd_drained", 32'(q2.size()), 32'd0);

        // Flush with two ops in flight and a third presented in the flush cycle
        if2.out_ready = 1'b0;
        drive2(1'b1, 4'd0, 32'd1, 32'd2, 5'd20); step();
        drive2(1'b1, 4'd1, 32'd9, 32'd4, 5'd21); step();
        chk("fl_inflight", 32'(if2.out_valid), 32'd1);
        drive2(1'b1, 4'd0, 32'd7, 32'd7, 5'd22);
        flush2 = 1'b1;
        #1 chk("fl_in_ready", 32'(if2.in_ready), 32'd0);
        step();
        flush2 = 1'b0;
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        if2.out_ready = 1'b1;
        chk("fl_out_valid", 32'(if2.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("fl_no_result", 32'(if2.out_valid), 32'd0);
        end

        // Asynchronous reset in the middle of a stream
        drive2(1'b1, 4'd3, 32'd1, 32'd2, 5'd13); step();
        drive2(1'b1, 4'd3, 32'd1, 32'd3, 5'd14); step();
        chk("ar_valid_before", 32'(if2.out_valid), 32'd1);
        chk("ar_ltu_before", 32'(if2.out_ltu), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("ar_out_valid", 32'(if2.out_valid), 32'd0);
        chk("ar_flags", 32'({if2.out_lt, if2.out_ltu, if2.out_eq}), 32'd0);
        chk("ar_out_res", if2.out_res, 32'd0);
        q2.delete();
        drive2(1'b0, 4'd0, 32'd0, 32'd0, 5'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        #1 chk("ar_in_ready", 32'(if2.in_ready), 32'd1);
        @(posedge clk); #1;

        // 4-stage back-pressure stream: 8 ADDs, consumer stalled in cycles 3..6
        for (int c = 0; c < 60 && out4_cnt < 8; c++) begin
            if4.out_ready = !(c >= 3 && c <= 6);
            if (sent4 < 8) begin
                if4.in_valid = 1'b1;
                if4.in_op    = 4'd0;
                if4.in_a     = 32'(sent4);
                if4.in_b     = 32'(sent4);
                if4.in_tag   = 5'(sent4);
            end else begin
                if4.in_valid = 1'b0;
            end
            step();
        end
        if4.in_valid  = 1'b0;
        if4.out_ready = 1'b1;
        repeat (3) step();
        chk("bp_sent", 32'(sent4), 32'd8);
        chk("bp_received", 32'(out4_cnt), 32'd8);
        chk("bp_in_ready_dropped", 32'(stall_seen), 32'd1);
        chk("bp_drained", 32'(q4.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
